icu_wide: RTL

//   Parametrised successor of the 1-bit MC14500B ICU: WIDTH-bit result register, bitwise logic unit.

---
 rtl/icu_wide_pkg.sv | 35 +++
 rtl/icu_wide_if.sv | 30 +++
 rtl/icu_wide_logic_unit.sv | 27 ++
 rtl/icu_wide.sv | 127 ++++++++++++
 4 files changed

// File: rtl/icu_wide_pkg.sv
// Opcode set and output strobe layout shared by the wide ICU, its logic unit and the bus interface.
package instructions;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } instruction_t;

  // Bit positions inside the registered strobe vector.
  localparam int FLAG_WRITE    = 0;
  localparam int FLAG_JMP      = 1;
  localparam int FLAG_RTN      = 2;
  localparam int FLAG_O        = 3;
  localparam int FLAG_F        = 4;
  localparam int ICU_OUT_FLAGS = 5;

  function automatic logic is_store(instruction_t op);
    return (op == OP_STO) || (op == OP_STOC);
  endfunction

endpackage

// File: rtl/icu_wide_if.sv
// Instruction/result handshake bundle of the wide ICU; slave is the ICU side, master the driver side.
interface icu_wide_if
  import instructions::*;
#(
  parameter int WIDTH = 8
);
  logic               instr_valid;
  logic               instr_ready;
  instruction_t       instruction;
  logic [WIDTH-1:0]   data_in;
  logic               out_valid;
  logic               out_ready;
  logic               write;
  logic [WIDTH-1:0]   data_out;
  logic               jmp;
  logic               rtn;
  logic               flag_o;
  logic               flag_f;
  logic [WIDTH-1:0]   rr_out;

  modport slave (
    input  instr_valid, instruction, data_in, out_ready,
    output instr_ready, out_valid, write, data_out, jmp, rtn, flag_o, flag_f, rr_out
  );

  modport master (
    output instr_valid, instruction, data_in, out_ready,
    input  instr_ready, out_valid, write, data_out, jmp, rtn, flag_o, flag_f, rr_out
  );
endinterface

// File: rtl/icu_wide_logic_unit.sv
// Combinational bitwise logic unit: next result register value from opcode, RR and masked operand.
module icu_logic_unit
  import instructions::*;
#(
  parameter int WIDTH = 8
) (
  input  instruction_t     op,
  input  logic [WIDTH-1:0] rr,
  input  logic [WIDTH-1:0] dm,
  output logic [WIDTH-1:0] rr_next
);

  always_comb begin
    rr_next = rr;
    case (op)
      OP_LD:   rr_next = dm;
      OP_LDC:  rr_next = ~dm;
      OP_AND:  rr_next = rr & dm;
      OP_ANDC: rr_next = rr & ~dm;
      OP_OR:   rr_next = rr | dm;
      OP_ORC:  rr_next = rr | ~dm;
      OP_XNOR: rr_next = ~(rr ^ dm);
      default: rr_next = rr;
    endcase
  end

endmodule

// File: rtl/icu_wide.sv
// WIDTH-bit successor of the MC14500B ICU with one registered output word behind valid/ready.
// Define ICU_BITMASK_EN for per-bit IEN/OEN masks; otherwise IEN/OEN are single all-or-nothing bits.
module icu_wide
  import instructions::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  icu_wide_if.slave bus
);

  logic                     fire_p0;
  logic                     exec_p0;
  logic [WIDTH-1:0]         dm_p0;
  logic [WIDTH-1:0]         rr_next_p0;
  logic [WIDTH-1:0]         store_val_p0;
  logic [ICU_OUT_FLAGS-1:0] flags_p0;
  logic [WIDTH-1:0]         dout_p0;

  logic [WIDTH-1:0]         rr;
  logic                     skip;
  logic [WIDTH-1:0]         ien_mask;
  logic [WIDTH-1:0]         oen_mask;

  logic                     vld_p1;
  logic [ICU_OUT_FLAGS-1:0] flags_p1;
  logic [WIDTH-1:0]         dout_p1;

`ifdef ICU_BITMASK_EN
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] oen_q;
  assign ien_mask = ien_q;
  assign oen_mask = oen_q;
`else
  logic ien_q;
  logic oen_q;
  assign ien_mask = {WIDTH{ien_q}};
  assign oen_mask = {WIDTH{oen_q}};
`endif

  assign bus.instr_ready = ~vld_p1 | bus.out_ready;
  assign fire_p0         = bus.instr_valid & bus.instr_ready;
  // A skipped instruction is still consumed and produces a word, but touches no state.
  assign exec_p0         = fire_p0 & ~skip;
  assign dm_p0           = bus.data_in & ien_mask;
  assign store_val_p0    = (bus.instruction == OP_STOC) ? ~rr : rr;

  icu_logic_unit #(.WIDTH(WIDTH)) u_logic (
    .op      (bus.instruction),
    .rr      (rr),
    .dm      (dm_p0),
    .rr_next (rr_next_p0)
  );

  always_comb begin
    flags_p0 = '0;
    dout_p0  = '0;
    if (exec_p0) begin
      case (bus.instruction)
        OP_STO, OP_STOC: begin
          if (|oen_mask) begin
            flags_p0[FLAG_WRITE] = 1'b1;
            dout_p0              = store_val_p0 & oen_mask;
          end
        end
        OP_JMP:  flags_p0[FLAG_JMP] = 1'b1;
        OP_RTN:  flags_p0[FLAG_RTN] = 1'b1;
        OP_NOPO: flags_p0[FLAG_O]   = 1'b1;
        OP_NOPF: flags_p0[FLAG_F]   = 1'b1;
        default: ;
      endcase
    end
  end

  // ---- p0 -> p1: architectural state and the registered output word ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      flags_p1 <= '0;
      dout_p1  <= '0;
      rr       <= '0;
      skip     <= 1'b0;
      ien_q    <= '0;
      oen_q    <= '0;
    end else begin
      if (fire_p0) begin
        vld_p1   <= 1'b1;
        flags_p1 <= flags_p0;
        dout_p1  <= dout_p0;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (fire_p0) begin
        if (skip) begin
          skip <= 1'b0;
        end else if (bus.instruction == OP_SKZ) begin
          skip <= (rr == '0);
        end else if (bus.instruction == OP_RTN) begin
          skip <= 1'b1;
        end
      end

      if (exec_p0) begin
        rr <= rr_next_p0;
`ifdef ICU_BITMASK_EN
        if (bus.instruction == OP_IEN) ien_q <= bus.data_in;
        if (bus.instruction == OP_OEN) oen_q <= dm_p0;
`else
        if (bus.instruction == OP_IEN) ien_q <= bus.data_in[0];
        if (bus.instruction == OP_OEN) oen_q <= dm_p0[0];
`endif
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.write     = vld_p1 & flags_p1[FLAG_WRITE] & is_store(OP_STO);
  assign bus.data_out  = (vld_p1 & flags_p1[FLAG_WRITE]) ? dout_p1 : '0;
  assign bus.jmp       = vld_p1 & flags_p1[FLAG_JMP];
  assign bus.rtn       = vld_p1 & flags_p1[FLAG_RTN];
  assign bus.flag_o    = vld_p1 & flags_p1[FLAG_O];
  assign bus.flag_f    = vld_p1 & flags_p1[FLAG_F];
  assign bus.rr_out    = rr;

endmodule
